buyruk_hizalama_kuyrugu: RTL and testbench
==========================================

Name: buyruk_hizalama_kuyrugu

Overview:
Parametrised fetch-side instruction queue that turns fetch words (FETCH_W bits) into a stream of aligned RV32IC instructions. It stores 16-bit parcels in a circular buffer, reassembles 32-bit instructions that straddle fetch words, and tags each instruction with its PC and a compressed flag. Valid/ready handshakes sit on both sides. It sits between the fetch unit and the decoder, and supports flush on a taken branch or jump.

Parameters:
FETCH_W, 32, fetch word width in bits; legal values are 32 and 64. P = FETCH_W/16 parcels per fetch word.
DERINLIK, 8, queue depth in 16-bit parcels; must be a power of 2 and at least 2*P.
PS_W, 32, PC width in bits.

Ports:
clk_i  in  1  clock; all logic on the rising edge.
rst_i  in  1  reset, synchronous, active-high.
getir_gecerli_i  in  1  fetch word valid.
getir_hazir_o  out  1  queue can accept a full fetch word.
getir_veri_i  in  FETCH_W  fetch word; parcel 0 is in the LSBs.
getir_ps_i  in  PS_W  byte address of the fetch word; bits [log2(FETCH_W/8)-1:1] give the first valid parcel.
temizle_i  in  1  flush, e.g. on a taken branch.
buyruk_gecerli_o  out  1  a complete instruction is at the head.
buyruk_hazir_i  in  1  decoder accepts the instruction.
buyruk_o  out  32  instruction; a compressed instruction is output as {16'h0, parcel}.
buyruk_ps_o  out  PS_W  PC of buyruk_o.
buyruk_sikistirilmis_o  out  1  buyruk_o is a 16-bit instruction.
doluluk_o  out  log2(DERINLIK)+1  parcels currently held.

Behaviour:
- Reset (rst_i=1 at the edge): read/write pointers, count and head PC go to 0; a "PC unknown" flag is set. After reset: doluluk_o=0, buyruk_gecerli_o=0, buyruk_o=0, buyruk_ps_o=0, buyruk_sikistirilmis_o=0, getir_hazir_o=1. Reset overrides every other input in the same cycle.
- getir_hazir_o = (DERINLIK - count) >= P. It uses the registered count only; a dequeue in the same cycle does not count.
- Fetch accept happens when getir_gecerli_i & getir_hazir_o & !temizle_i.
  - Offset k = getir_ps_i[log2(FETCH_W/8)-1:1]. Parcels k..P-1 are written in order; parcels below k are discarded. Count rises by P-k.
  - If "PC unknown" is set, the head PC is loaded with getir_ps_i with bits [log2(FETCH_W/8)-1:0] cleared, plus 2*k, and the flag is cleared.
- Head decode, combinational from registered storage:
  - Head parcel [1:0] != 2'b11 and count >= 1: compressed. buyruk_gecerli_o=1, buyruk_sikistirilmis_o=1, buyruk_o={16'h0, head}.
  - Head parcel [1:0] == 2'b11 and count >= 2: 32-bit instruction. buyruk_o={head+1, head}, buyruk_sikistirilmis_o=0.
  - Head parcel [1:0] == 2'b11 and count == 1: buyruk_gecerli_o=0, waiting for the upper half.
  - Whenever buyruk_gecerli_o=0, buyruk_o, buyruk_sikistirilmis_o and buyruk_ps_o are all 0.
- Dequeue happens when buyruk_gecerli_o & buyruk_hazir_i. The read pointer and head PC advance by 1 parcel/+2 bytes (compressed) or 2 parcels/+4 bytes (32-bit). At most one instruction leaves per cycle.
- Simultaneous accept and dequeue: next count = count + (P-k) - consumed. Pointers wrap modulo DERINLIK.
- Latency: a parcel accepted at edge N can appear on the output in the cycle after edge N. There is no input-to-output bypass.
- Flush (temizle_i=1, rst_i=0):
  - buyruk_gecerli_o is forced to 0 in that cycle, so no dequeue occurs.
  - Any fetch offered that cycle is discarded.
  - At the edge: count=0, pointers=0, "PC unknown" set. The following cycle has doluluk_o=0 and getir_hazir_o=1.
- Overflow is impossible by construction. Back-to-back fetches at full rate are legal while getir_hazir_o=1.
- Only 16-bit and 32-bit instruction lengths are supported; [1:0]==11 always means 32-bit.

Test Plan:
1. FETCH_W=32, reset, then fetch 32'h00A00093 at PC 32'h100 → next cycle buyruk_gecerli_o=1, buyruk_o=32'h00A00093, ps=32'h100, sikistirilmis=0; after the dequeue, doluluk_o=0.
2. Fetch 32'h45014485 at PC 32'h200 with buyruk_hazir_i=1 → two consecutive outputs: 32'h00004485@32'h200 and 32'h00004501@32'h202, both sikistirilmis=1. Repeat with FETCH_W=64, word 64'h4521452945014485 at PC 32'h200 → four outputs, PCs 32'h200/202/204/206.
3. Straddle, FETCH_W=32:
   - Fetch 32'h00934505 at 32'h300 → output 32'h00004505@32'h300; then buyruk_gecerli_o=0 with doluluk_o=1.
   - Fetch 32'h452100A0 → outputs 32'h00A00093@32'h302 (sikistirilmis=0), then 32'h00004521@32'h306.
4. Backpressure: hold buyruk_hazir_i=0 and push four 32-bit words (DERINLIK=8) → doluluk_o=8 and getir_hazir_o=0. A fifth word held valid is not accepted. Release buyruk_hazir_i → all instructions come out in order with correct PCs, and getir_hazir_o returns to 1 once doluluk_o ≤ 6.
5. Flush: with 3 parcels queued, assert temizle_i together with getir_gecerli_i → that cycle buyruk_gecerli_o=0, next cycle doluluk_o=0. Then fetch 32'h45050000 at PC 32'h402 → low parcel dropped, output 32'h00004505@32'h402, sikistirilmis=1.
6. Assert rst_i with 5 parcels queued and fetch/flush both active → next cycle doluluk_o=0, buyruk_gecerli_o=0, buyruk_o=0, getir_hazir_o=1.

Source files
------------

// File: rtl/buyruk_hizalama_kuyrugu.sv
// Fetch-side instruction queue: stores 16-bit parcels in a circular buffer and
// presents aligned RV32IC instructions (16- or 32-bit) with their PC to the decoder.
module buyruk_hizalama_kuyrugu #(
  parameter int unsigned FETCH_W  = 32,
  parameter int unsigned DERINLIK = 8,
  parameter int unsigned PS_W     = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        getir_gecerli_i,
  output logic                        getir_hazir_o,
  input  logic [FETCH_W-1:0]          getir_veri_i,
  input  logic [PS_W-1:0]             getir_ps_i,
  input  logic                        temizle_i,
  output logic                        buyruk_gecerli_o,
  input  logic                        buyruk_hazir_i,
  output logic [31:0]                 buyruk_o,
  output logic [PS_W-1:0]             buyruk_ps_o,
  output logic                        buyruk_sikistirilmis_o,
  output logic [$clog2(DERINLIK):0]   doluluk_o
);

  localparam int unsigned P     = FETCH_W / 16;
  localparam int unsigned OFF_W = $clog2(FETCH_W / 8);
  localparam int unsigned K_W   = OFF_W - 1;
  localparam int unsigned PTR_W = $clog2(DERINLIK);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [15:0]      mem [DERINLIK];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PS_W-1:0]  head_ps_q, head_ps_d;
  logic             ps_bilinmiyor_q, ps_bilinmiyor_d;

  logic [K_W-1:0]   k;
  logic             kabul;
  logic             cikis;
  logic             sik;
  logic             bas_hazir;
  logic [CNT_W-1:0] eklenen;
  logic [CNT_W-1:0] tuketilen;
  logic [15:0]      bas;
  logic [15:0]      bas_ust;
  logic [PS_W-1:0]  hizali_ps;

  assign k             = getir_ps_i[OFF_W-1:1];
  assign getir_hazir_o = (CNT_W'(DERINLIK) - count_q) >= CNT_W'(P);
  assign kabul         = getir_gecerli_i & getir_hazir_o & ~temizle_i;
  assign doluluk_o     = count_q;

  // Head decode straight from registered storage; a flush hides the head.
  assign bas       = mem[rd_ptr_q];
  assign bas_ust   = mem[rd_ptr_q + PTR_W'(1)];
  assign sik       = (bas[1:0] != 2'b11);
  assign bas_hazir = ~temizle_i & (sik ? (count_q >= CNT_W'(1)) : (count_q >= CNT_W'(2)));
  assign cikis     = bas_hazir & buyruk_hazir_i;

  // PC of the first kept parcel: word-aligned fetch address plus the parcel offset.
  assign hizali_ps = (getir_ps_i & ~PS_W'(FETCH_W / 8 - 1)) + PS_W'({k, 1'b0});

  // Parcel storage: parcels below the offset are dropped, the rest packed in order.
  always_ff @(posedge clk_i) begin
    if (kabul) begin
      for (int unsigned i = 0; i < P; i++) begin
        if (K_W'(i) >= k) begin
          mem[wr_ptr_q + PTR_W'(i) - PTR_W'(k)] <= getir_veri_i[16*i +: 16];
        end
      end
    end
  end

  // Next-state for pointers, count and head PC.
  always_comb begin
    eklenen         = '0;
    tuketilen       = '0;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    head_ps_d       = head_ps_q;
    ps_bilinmiyor_d = ps_bilinmiyor_q;

    if (kabul) begin
      eklenen = CNT_W'(P) - CNT_W'(k);
    end
    if (cikis) begin
      tuketilen = sik ? CNT_W'(1) : CNT_W'(2);
    end

    rd_ptr_d  = rd_ptr_q + PTR_W'(tuketilen);
    wr_ptr_d  = wr_ptr_q + PTR_W'(eklenen);
    count_d   = count_q + eklenen - tuketilen;
    head_ps_d = head_ps_q + PS_W'({tuketilen, 1'b0});

    // Count is zero whenever the PC is unknown, so no dequeue competes here.
    if (kabul && ps_bilinmiyor_q) begin
      head_ps_d       = hizali_ps;
      ps_bilinmiyor_d = 1'b0;
    end

    if (temizle_i) begin
      rd_ptr_d        = '0;
      wr_ptr_d        = '0;
      count_d         = '0;
      ps_bilinmiyor_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      count_q         <= '0;
      head_ps_q       <= '0;
      ps_bilinmiyor_q <= 1'b1;
    end else begin
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      count_q         <= count_d;
      head_ps_q       <= head_ps_d;
      ps_bilinmiyor_q <= ps_bilinmiyor_d;
    end
  end

  // Decoder-side outputs are zero whenever no instruction is presented.
  always_comb begin
    buyruk_gecerli_o       = bas_hazir;
    buyruk_o               = '0;
    buyruk_ps_o            = '0;
    buyruk_sikistirilmis_o = 1'b0;
    if (bas_hazir) begin
      buyruk_ps_o            = head_ps_q;
      buyruk_sikistirilmis_o = sik;
      buyruk_o               = sik ? {16'h0000, bas} : {bas_ust, bas};
    end
  end

endmodule

// File: tb/tb_buyruk_hizalama_kuyrugu.sv
// Directed bench for the instruction alignment queue: a per-cycle vector table
// for the 32-bit fetch instance plus hand sequences for multi-cycle cases.
module tb_buyruk_hizalama_kuyrugu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        gv, tz, hz;
  logic [31:0] veri, ps;
  logic        gh, bv, bsik;
  logic [31:0] b, bps;
  logic [3:0]  dol;

  logic        gv64, tz64, hz64;
  logic [63:0] veri64;
  logic [31:0] ps64;
  logic        gh64, bv64, bsik64;
  logic [31:0] b64, bps64;
  logic [3:0]  dol64;

  buyruk_hizalama_kuyrugu #(.FETCH_W(32), .DERINLIK(8), .PS_W(32)) u32 (
    .clk_i(clk), .rst_i(rst),
    .getir_gecerli_i(gv), .getir_hazir_o(gh), .getir_veri_i(veri), .getir_ps_i(ps),
    .temizle_i(tz),
    .buyruk_gecerli_o(bv), .buyruk_hazir_i(hz), .buyruk_o(b), .buyruk_ps_o(bps),
    .buyruk_sikistirilmis_o(bsik), .doluluk_o(dol)
  );

  buyruk_hizalama_kuyrugu #(.FETCH_W(64), .DERINLIK(8), .PS_W(32)) u64 (
    .clk_i(clk), .rst_i(rst),
    .getir_gecerli_i(gv64), .getir_hazir_o(gh64), .getir_veri_i(veri64), .getir_ps_i(ps64),
    .temizle_i(tz64),
    .buyruk_gecerli_o(bv64), .buyruk_hazir_i(hz64), .buyruk_o(b64), .buyruk_ps_o(bps64),
    .buyruk_sikistirilmis_o(bsik64), .doluluk_o(dol64)
  );

  typedef struct {
    logic        gv;
    logic [31:0] veri;
    logic [31:0] ps;
    logic        tz;
    logic        hz;
    logic        e_v;
    logic [31:0] e_b;
    logic [31:0] e_ps;
    logic        e_sik;
    logic [3:0]  e_dol;
    logic        e_gh;
  } vek_t;

  localparam int NV = 20;
  vek_t tablo [NV];

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", ad, act, exp);
    end
  endtask

  function automatic vek_t vk(input int unsigned g, input int unsigned v, input int unsigned p,
                              input int unsigned t, input int unsigned h, input int unsigned ev,
                              input int unsigned eb, input int unsigned eps, input int unsigned es,
                              input int unsigned ed, input int unsigned eg);
    vek_t r;
    r.gv = 1'(g); r.veri = v; r.ps = p; r.tz = 1'(t); r.hz = 1'(h);
    r.e_v = 1'(ev); r.e_b = eb; r.e_ps = eps; r.e_sik = 1'(es); r.e_dol = 4'(ed); r.e_gh = 1'(eg);
    return r;
  endfunction

  task automatic adim();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] exp_b [5];
  logic [31:0] exp_ps [5];
  logic [31:0] got_b [5];
  logic [31:0] got_ps [5];
  logic        got_s [5];

  initial begin
    rst = 1'b1; gv = 0; tz = 0; hz = 0; veri = '0; ps = '0;
    gv64 = 0; tz64 = 0; hz64 = 0; veri64 = '0; ps64 = '0;

    //           gv  veri          ps      tz hz  v  b             ps      sik dol gh
    tablo[0]  = vk(1, 'h00A00093, 'h100,  0, 1,  0, 0,            0,      0,  0,  1);
    tablo[1]  = vk(0, 0,          0,      0, 1,  1, 'h00A00093,   'h100,  0,  2,  1);
    tablo[2]  = vk(0, 0,          0,      1, 1,  0, 0,            0,      0,  0,  1);
    tablo[3]  = vk(1, 'h45014485, 'h200,  0, 1,  0, 0,            0,      0,  0,  1);
    tablo[4]  = vk(0, 0,          0,      0, 1,  1, 'h4485,       'h200,  1,  2,  1);
    tablo[5]  = vk(0, 0,          0,      0, 1,  1, 'h4501,       'h202,  1,  1,  1);
    tablo[6]  = vk(0, 0,          0,      1, 1,  0, 0,            0,      0,  0,  1);
    tablo[7]  = vk(1, 'h00934505, 'h300,  0, 1,  0, 0,            0,      0,  0,  1);
    tablo[8]  = vk(0, 0,          0,      0, 1,  1, 'h4505,       'h300,  1,  2,  1);
    tablo[9]  = vk(1, 'h452100A0, 'h304,  0, 1,  0, 0,            0,      0,  1,  1);
    tablo[10] = vk(0, 0,          0,      0, 1,  1, 'h00A00093,   'h302,  0,  3,  1);
    tablo[11] = vk(0, 0,          0,      0, 1,  1, 'h4521,       'h306,  1,  1,  1);
    tablo[12] = vk(0, 0,          0,      0, 1,  0, 0,            0,      0,  0,  1);
    tablo[13] = vk(0, 0,          0,      1, 0,  0, 0,            0,      0,  0,  1);
    tablo[14] = vk(1, 'h44854485, 'h3FE,  0, 0,  0, 0,            0,      0,  0,  1);
    tablo[15] = vk(1, 'h45014501, 'h400,  0, 0,  1, 'h4485,       'h3FE,  1,  1,  1);
    tablo[16] = vk(1, 'h12345678, 'h404,  1, 1,  0, 0,            0,      0,  3,  1);
    tablo[17] = vk(1, 'h45050000, 'h402,  0, 0,  0, 0,            0,      0,  0,  1);
    tablo[18] = vk(0, 0,          0,      0, 1,  1, 'h4505,       'h402,  1,  1,  1);
    tablo[19] = vk(0, 0,          0,      0, 0,  0, 0,            0,      0,  0,  1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      gv = tablo[i].gv; veri = tablo[i].veri; ps = tablo[i].ps; tz = tablo[i].tz; hz = tablo[i].hz;
      @(negedge clk);
      chk($sformatf("r%0d_gecerli", i), 32'(bv),   32'(tablo[i].e_v));
      chk($sformatf("r%0d_buyruk", i),  b,         tablo[i].e_b);
      chk($sformatf("r%0d_ps", i),      bps,       tablo[i].e_ps);
      chk($sformatf("r%0d_sik", i),     32'(bsik), 32'(tablo[i].e_sik));
      chk($sformatf("r%0d_doluluk", i), 32'(dol),  32'(tablo[i].e_dol));
      chk($sformatf("r%0d_getir_hazir", i), 32'(gh), 32'(tablo[i].e_gh));
      adim();
    end
    gv = 0; tz = 0; hz = 0;

    // 64-bit fetch word carrying four compressed instructions.
    begin
      int n;
      exp_b[0] = 32'h4485; exp_b[1] = 32'h4501; exp_b[2] = 32'h4529; exp_b[3] = 32'h4521;
      gv64 = 1; veri64 = 64'h4521452945014485; ps64 = 32'h200; hz64 = 1;
      adim();
      gv64 = 0;
      n = 0;
      for (int c = 0; c < 12 && n < 4; c++) begin
        @(negedge clk);
        if (bv64) begin
          got_b[n] = b64; got_ps[n] = bps64; got_s[n] = bsik64; n++;
        end
        adim();
      end
      chk("w64_count", 32'(n), 32'd4);
      for (int j = 0; j < n; j++) begin
        chk($sformatf("w64_buyruk%0d", j), got_b[j], exp_b[j]);
        chk($sformatf("w64_ps%0d", j), got_ps[j], 32'h200 + 32'(2 * j));
        chk($sformatf("w64_sik%0d", j), 32'(got_s[j]), 32'd1);
      end
      @(negedge clk);
      chk("w64_doluluk_bos", 32'(dol64), 32'd0);
      adim();
    end

    // Backpressure: fill to depth, hold a fifth word, then drain in order.
    begin
      int n;
      logic kabul;
      exp_b[0] = 32'h00100093; exp_b[1] = 32'h00200113; exp_b[2] = 32'h00300193;
      exp_b[3] = 32'h00400213; exp_b[4] = 32'h00500293;
      for (int j = 0; j < 5; j++) exp_ps[j] = 32'h500 + 32'(4 * j);
      tz = 1; adim(); tz = 0;
      hz = 0;
      for (int w = 0; w < 4; w++) begin
        gv = 1; veri = exp_b[w]; ps = exp_ps[w];
        adim();
      end
      veri = exp_b[4]; ps = exp_ps[4];
      @(negedge clk);
      chk("bp_doluluk_dolu", 32'(dol), 32'd8);
      chk("bp_getir_hazir_0", 32'(gh), 32'd0);
      adim();
      @(negedge clk);
      chk("bp_besinci_bekliyor", 32'(dol), 32'd8);
      adim();
      hz = 1;
      n = 0;
      for (int c = 0; c < 30 && (n < 5 || gv); c++) begin
        @(negedge clk);
        chk($sformatf("bp_hazir_c%0d", c), 32'(gh), 32'(dol <= 4'd6));
        kabul = gv & gh;
        if (bv) begin
          if (n < 5) begin got_b[n] = b; got_ps[n] = bps; end
          n++;
        end
        adim();
        if (kabul) gv = 0;
      end
      chk("bp_count", 32'(n), 32'd5);
      for (int j = 0; j < 5 && j < n; j++) begin
        chk($sformatf("bp_buyruk%0d", j), got_b[j], exp_b[j]);
        chk($sformatf("bp_ps%0d", j), got_ps[j], exp_ps[j]);
      end
      gv = 0; hz = 0;
    end

    // Reset wins over a simultaneous fetch and flush with five parcels queued.
    tz = 1; adim(); tz = 0;
    gv = 1; veri = 32'h44854485; ps = 32'h602; adim();
    veri = 32'h45014501; ps = 32'h604; adim();
    veri = 32'h45214521; ps = 32'h608; adim();
    gv = 0;
    @(negedge clk);
    chk("rst_oncesi_doluluk", 32'(dol), 32'd5);
    chk("rst_oncesi_buyruk", b, 32'h4485);
    chk("rst_oncesi_ps", bps, 32'h602);
    adim();
    rst = 1; gv = 1; tz = 1; hz = 1; veri = 32'h00A00093; ps = 32'h700;
    adim();
    rst = 0; gv = 0; tz = 0; hz = 0;
    @(negedge clk);
    chk("rst_doluluk", 32'(dol), 32'd0);
    chk("rst_gecerli", 32'(bv), 32'd0);
    chk("rst_buyruk", b, 32'd0);
    chk("rst_ps", bps, 32'd0);
    chk("rst_sik", 32'(bsik), 32'd0);
    chk("rst_getir_hazir", 32'(gh), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
